score_bcd_converter: RTL

SCORE_BCD_CONVERTER -- requirements
Module: score_bcd_converter

---
 rtl/score_bcd_converter_pkg.sv | 17 +
 rtl/score_bcd_converter_bcd_digit_adj.sv | 14 +
 rtl/score_bcd_converter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/score_bcd_converter_pkg.sv
// Shared types and constants for the score binary-to-BCD converter.
//   state_t           : converter FSM states
//   bcd_digit_t       : one 4-bit BCD digit
//   MAX_SCORE_DEFAULT : largest value the six-digit leaderboard can show
package score_bcd_converter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int MAX_SCORE_DEFAULT = 999999;

endpackage

// File: rtl/score_bcd_converter_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next digit.
//   din  : scratch digit before the shift
//   dout : corrected digit
module bcd_digit_adj
  import score_bcd_converter_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  assign dout = (din >= 4'd5) ? bcd_digit_t'(din + 4'd3) : din;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter for the leaderboard score display.
// A request in IDLE captures the (clamped) score, WIDTH double-dabble
// iterations run one per cycle, then the digits and the overflow flag are
// published together for a single done cycle.
//   clk, reset        : clock, asynchronous active-high reset
//   start, score      : conversion request and binary value
//   busy, done        : conversion in progress / one-cycle result strobe
//   overflow          : last accepted score was above MAX_SCORE
//   display_*         : registered BCD digits, ones..hundred-thousands
//
// state    | meaning
// ST_IDLE  | waiting for start; outputs hold last result
// ST_SHIFT | one add-3/shift iteration per cycle, WIDTH cycles
// ST_DONE  | new digits on the outputs, done pulse
module score_bcd_converter
  import score_bcd_converter_pkg::*;
#(
  parameter int WIDTH     = 20,
  parameter int DIGITS    = 6,
  parameter int MAX_SCORE = MAX_SCORE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] score,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       display_ones,
  output logic [3:0]       display_tens,
  output logic [3:0]       display_hundreds,
  output logic [3:0]       display_thousands,
  output logic [3:0]       display_tthousands,
  output logic [3:0]       display_hthousands
);

  localparam int SW    = 4 * DIGITS;
  localparam int PW    = (SW > 24) ? SW : 24;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_SCORE);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] working;
  logic [SW-1:0]    scratch, scratch_adj, scratch_next;
  logic [CNT_W-1:0] iter;
  logic             overflow_pending;
  logic [SW-1:0]    disp_q;
  logic [PW-1:0]    disp_pad;
  logic             last_iter;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[4*i +: 4]),
      .dout (scratch_adj[4*i +: 4])
    );
  end

  // Shift the corrected scratch and the working value left as one word.
  assign scratch_next = {scratch_adj[SW-2:0], working[WIDTH-1]};
  assign last_iter    = (iter == LAST_ITER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_SHIFT;
      ST_SHIFT: if (last_iter) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      working          <= '0;
      scratch          <= '0;
      iter             <= '0;
      overflow_pending <= 1'b0;
      disp_q           <= '0;
      overflow         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            working          <= (score > MAX_W) ? MAX_W : score;
            scratch          <= '0;
            iter             <= '0;
            overflow_pending <= (score > MAX_W);
          end
        end
        ST_SHIFT: begin
          scratch <= scratch_next;
          working <= working << 1;
          iter    <= iter + 1'b1;
          // Publish on the edge entering DONE so digits and done coincide.
          if (last_iter) begin
            disp_q   <= scratch_next;
            overflow <= overflow_pending;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  assign disp_pad           = PW'(disp_q);
  assign display_ones       = disp_pad[3:0];
  assign display_tens       = disp_pad[7:4];
  assign display_hundreds   = disp_pad[11:8];
  assign display_thousands  = disp_pad[15:12];
  assign display_tthousands = disp_pad[19:16];
  assign display_hthousands = disp_pad[23:20];

endmodule
